// File: rtl/alu_card_p.sv
// alu_card_p: WIDTH-bit ALU card with register file and start/busy/done handshake.
// Define ALU_CARD_MUL_EN to compile in the shift-add multiplier (op 11).
module alu_card_p #(
    parameter int WIDTH = 8,
    parameter int NREG = 4,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [ADDR_W-1:0] rsel,
    output logic [WIDTH-1:0]  res,
    output logic              busy,
    output logic              done,
    output logic              sign_reg,
    output logic              z_reg,
    output logic              c_reg,
    output logic              v_reg
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_ADC = 4'd6;
    localparam logic [3:0] OP_SBC = 4'd7;
    localparam logic [3:0] OP_LDR = 4'd8;
    localparam logic [3:0] OP_STR = 4'd9;
    localparam logic [3:0] OP_CLC = 4'd10;
`ifdef ALU_CARD_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd11;
`endif

    logic [WIDTH-1:0] rf [NREG];

    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             ovf;

    logic [WIDTH-1:0] r_val;
    logic             upd_sz;
    logic             upd_cv;
    logic             c_val;
    logic             v_val;
    logic             clr_c;
    logic             rf_we;
    logic             mul_go;
    logic             go;

    assign go = start & ~busy;

    // Subtraction is a + ~b + carry-in, so c is the no-borrow flag
    always_comb begin
        b_eff = b;
        cin   = 1'b0;
        case (op)
            OP_SUB: begin
                b_eff = ~b;
                cin   = 1'b1;
            end
            OP_ADC: cin = c_reg;
            OP_SBC: begin
                b_eff = ~b;
                cin   = c_reg;
            end
            default: ;
        endcase
    end

    assign sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1])
               && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        r_val  = res;
        upd_sz = 1'b0;
        upd_cv = 1'b0;
        c_val  = c_reg;
        v_val  = v_reg;
        clr_c  = 1'b0;
        rf_we  = 1'b0;
        mul_go = 1'b0;
        case (op)
            OP_AND: begin
                r_val  = a & b;
                upd_sz = 1'b1;
            end
            OP_OR: begin
                r_val  = a | b;
                upd_sz = 1'b1;
            end
            OP_NOT: begin
                r_val  = ~a;
                upd_sz = 1'b1;
            end
            OP_XOR: begin
                r_val  = a ^ b;
                upd_sz = 1'b1;
            end
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                r_val  = sum[WIDTH-1:0];
                upd_sz = 1'b1;
                upd_cv = 1'b1;
                c_val  = sum[WIDTH];
                v_val  = ovf;
            end
            OP_LDR: begin
                r_val  = rf[rsel];
                upd_sz = 1'b1;
            end
            OP_STR: begin
                r_val  = b;
                upd_sz = 1'b1;
                rf_we  = 1'b1;
            end
            OP_CLC: clr_c = 1'b1;
`ifdef ALU_CARD_MUL_EN
            OP_MUL: mul_go = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (go && rf_we) begin
            rf[rsel] <= b;
        end
    end

`ifdef ALU_CARD_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state;
    state_t             state_d;
    logic               mul_last;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [CNT_W-1:0]   cnt;

    assign busy    = (state == S_MUL);
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d  = state;
        mul_last = 1'b0;
        case (state)
            S_IDLE: if (go && mul_go) state_d = S_MUL;
            S_MUL: begin
                if (cnt == CNT_LAST) begin
                    state_d  = S_IDLE;
                    mul_last = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One multiplier bit consumed per cycle, LSB first
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (go && mul_go) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (busy) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_nxt;
            cnt    <= cnt + CNT_W'(1);
        end
    end
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            res      <= '0;
            done     <= 1'b0;
            sign_reg <= 1'b0;
            z_reg    <= 1'b0;
            c_reg    <= 1'b0;
            v_reg    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                if (!mul_go) done <= 1'b1;
                if (upd_sz) begin
                    res      <= r_val;
                    sign_reg <= r_val[WIDTH-1];
                    z_reg    <= (r_val == '0);
                end
                if (upd_cv) begin
                    c_reg <= c_val;
                    v_reg <= v_val;
                end
                if (clr_c) c_reg <= 1'b0;
            end
`ifdef ALU_CARD_MUL_EN
            if (mul_last) begin
                res      <= acc_nxt[WIDTH-1:0];
                sign_reg <= acc_nxt[WIDTH-1];
                z_reg    <= (acc_nxt[WIDTH-1:0] == '0);
                c_reg    <= |acc_nxt[2*WIDTH-1:WIDTH];
                v_reg    <= 1'b0;
                done     <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_card_p.sv
// Directed self-checking bench for alu_card_p (WIDTH=8, NREG=4).
// Covers the multiplier only when ALU_CARD_MUL_EN is defined.
module tb_alu_card_p;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic [1:0] rsel = 2'd0;
    logic [7:0] res;
    logic       busy;
    logic       done;
    logic       sign_reg;
    logic       z_reg;
    logic       c_reg;
    logic       v_reg;

    int total = 0;
    int bad = 0;

    alu_card_p #(.WIDTH(8), .NREG(4)) dut (
        .clk(clk),
        .clear(clear),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .rsel(rsel),
        .res(res),
        .busy(busy),
        .done(done),
        .sign_reg(sign_reg),
        .z_reg(z_reg),
        .c_reg(c_reg),
        .v_reg(v_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive a request at a negedge and move to the next negedge;
    // start stays high so calls can be chained back to back.
    task automatic issue(input logic [3:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [1:0] r);
        op = o;
        a = x;
        b = y;
        rsel = r;
        start = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [3:0] flags();
        return {sign_reg, z_reg, c_reg, v_reg};
    endfunction

    initial begin
        #8;
        check("rst_res", res, 8'h00);
        check("rst_flags", flags(), 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        #4 clear = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            issue(4'd8, 8'h00, 8'h00, 2'(i));
            check($sformatf("ldr_rst%0d", i), res, 8'h00);
            check($sformatf("ldr_rst%0d_done", i), done, 1'b1);
        end
        start = 1'b0;
        @(negedge clk);
        check("idle_done", done, 1'b0);

        issue(4'd4, 8'h7F, 8'h01, 2'd0);
        start = 1'b0;
        check("add_res", res, 8'h80);
        check("add_flags", flags(), 4'b1001);
        check("add_done", done, 1'b1);
        @(negedge clk);
        check("add_done_drop", done, 1'b0);
        check("add_hold", res, 8'h80);

        issue(4'd5, 8'h05, 8'h05, 2'd0);
        check("sub_res", res, 8'h00);
        check("sub_flags", flags(), 4'b0110);
        issue(4'd6, 8'hFF, 8'h00, 2'd0);
        check("adc_res", res, 8'h00);
        check("adc_flags", flags(), 4'b0110);
        issue(4'd10, 8'h33, 8'h44, 2'd0);
        check("clc_res", res, 8'h00);
        check("clc_flags", flags(), 4'b0100);

        issue(4'd9, 8'h00, 8'hA5, 2'd2);
        check("str_res", res, 8'hA5);
        check("str_flags", flags(), 4'b1000);
        issue(4'd8, 8'h00, 8'h00, 2'd2);
        check("ldr2_res", res, 8'hA5);
        check("ldr2_flags", flags(), 4'b1000);
        check("ldr2_done", done, 1'b1);
        issue(4'd8, 8'h00, 8'h00, 2'd1);
        check("ldr1_res", res, 8'h00);
        check("ldr1_flags", flags(), 4'b0100);

        issue(4'd12, 8'hFF, 8'hFF, 2'd0);
        check("nop_res", res, 8'h00);
        check("nop_flags", flags(), 4'b0100);
        check("nop_done", done, 1'b1);

        issue(4'd3, 8'hF0, 8'h3C, 2'd0);
        check("xor_res", res, 8'hCC);
        check("xor_flags", flags(), 4'b1000);
        issue(4'd7, 8'h10, 8'h20, 2'd0);
        check("sbc_res", res, 8'hEF);
        check("sbc_flags", flags(), 4'b1000);
        issue(4'd4, 8'h40, 8'h40, 2'd0);
        start = 1'b0;
        check("add2_res", res, 8'h80);
        check("add2_flags", flags(), 4'b1001);
        @(negedge clk);

`ifdef ALU_CARD_MUL_EN
        begin
            int n;
            int busy_cnt;
            logic saw_done;
            issue(4'd11, 8'h12, 8'h11, 2'd0);
            start = 1'b0;
            check("mul_busy", busy, 1'b1);
            check("mul_hold", res, 8'h80);
            n = 1;
            busy_cnt = 0;
            while (!done && n < 40) begin
                if (busy) busy_cnt++;
                if (n == 3) begin
                    op = 4'd0;
                    a = 8'hFF;
                    b = 8'h0F;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            check("mul_latency", n, 9);
            check("mul_busy_cycles", busy_cnt, 8);
            check("mul_res", res, 8'h32);
            check("mul_flags", flags(), 4'b0010);
            @(negedge clk);
            check("mul_done_drop", done, 1'b0);
            check("mul_ignored", res, 8'h32);

            issue(4'd11, 8'h12, 8'h11, 2'd0);
            start = 1'b0;
            repeat (3) @(negedge clk);
            clear = 1'b1;
            #1;
            check("abort_busy", busy, 1'b0);
            check("abort_res", res, 8'h00);
            check("abort_flags", flags(), 4'b0000);
            #1 clear = 1'b0;
            saw_done = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (done) saw_done = 1'b1;
            end
            check("abort_no_done", saw_done, 1'b0);
        end
`else
        issue(4'd11, 8'h03, 8'h03, 2'd0);
        start = 1'b0;
        check("op11_done", done, 1'b1);
        check("op11_busy", busy, 1'b0);
        check("op11_res", res, 8'h80);
        check("op11_flags", flags(), 4'b1001);
        @(negedge clk);
        check("op11_done_drop", done, 1'b0);
`endif

        @(negedge clk);
        #2 clear = 1'b1;
        #1 check("clr2_res", res, 8'h00);
        #1 clear = 1'b0;
        @(negedge clk);
        issue(4'd8, 8'h00, 8'h00, 2'd2);
        start = 1'b0;
        check("clr2_rf", res, 8'h00);
        check("clr2_flags", flags(), 4'b0100);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_card_p.md
# alu_card_p

Parametrised successor to the 8-bit ALU card. It performs logic, add/subtract and carry-chained arithmetic on WIDTH-bit operands, and provides an NREG-entry register file. An optional multi-cycle shift-add multiplier can be compiled in. Results and status flags are registered, and every operation is started with a start/busy/done handshake, so a sequencer can chain cards.

## Interface
- WIDTH, 8: operand, result and register width; must be at least 2.
- NREG, 4: register-file depth; must be a power of 2 and at least 2.
  - ADDR_W = clog2(NREG) is derived, not settable.
- clk  in  1  rising-edge clock.
- clear  in  1  reset; one clock; reset is asynchronous and active-high.
- start  in  1  operation request; sampled on rising edges only while busy=0.
- op  in  4  operation code, sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B / store data, sampled with start.
- rsel  in  ADDR_W  register-file index for LDR/STR, sampled with start.
- res  out  WIDTH  registered result.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse marking operation completion.
- sign_reg, z_reg, c_reg, v_reg  out  1 each  registered sign, zero, carry and overflow flags.

## Operation
- Opcodes:
  - 0 AND: res=a&b.
  - 1 OR: res=a|b.
  - 2 NOT: res=~a.
  - 3 XOR: res=a^b.
  - 4 ADD: res=a+b.
  - 5 SUB: res=a+~b+1.
  - 6 ADC: res=a+b+c_reg.
  - 7 SBC: res=a+~b+c_reg.
  - 8 LDR: res=rf[rsel].
  - 9 STR: rf[rsel]<=b, res=b.
  - 10 CLC: c_reg<=0; res and other flags unchanged.
  - 11 MUL.
  - 12-15 reserved: NOP.
- All arithmetic is done in WIDTH+1 bits.
  - c_reg = bit WIDTH of the sum. For SUB/SBC this is the no-borrow flag: 1 when a>=b unsigned (SUB).
  - v_reg = signed overflow: (a[W-1]==b'[W-1]) && (res[W-1]!=a[W-1]), where b' is the effective second addend.
- Flag update rules:
  - sign_reg=res[W-1] and z_reg=(res==0) update on ops 0-9 and 11.
  - c_reg/v_reg update on ops 4-7 and 11; they hold on logic, LDR and STR.
- MUL gives the low WIDTH bits of unsigned a*b in res.
  - c_reg=1 if the upper WIDTH bits are nonzero; v_reg=0.
  - Implemented as shift-add, one multiplier bit per cycle, in a 2W-bit accumulator.
- FSM states: IDLE, MUL.
  - IDLE→MUL on start with op=11 (when compiled in).
  - MUL→IDLE after WIDTH iterations.
  - All other ops complete in IDLE.
- start is ignored while busy=1; it is not queued.
- Reset values: res=0, all flags 0, busy=0, done=0, every rf entry 0, state IDLE.
- clear mid-MUL aborts immediately: no done pulse, and res and flags take their reset values.

## Timing
- Single-cycle ops: res, flags and rf update on the edge that samples start. done=1 for exactly the following cycle.
- Back-to-back single-cycle starts on consecutive edges are legal; done then stays high continuously.
- STR followed by LDR of the same index on the next edge returns the new data.
- MUL:
  - Operands are captured at edge 0 and busy=1 from then on.
  - Iterations run on edges 1..WIDTH.
  - At edge WIDTH, res and flags load, busy falls and done=1 for one cycle.
  - Latency from start edge to done: WIDTH+1 cycles (single-cycle ops: 1).
  - res and flags hold their previous values while busy=1.

## Configuration
- ALU_CARD_MUL_EN defined: the MUL state, accumulator and op 11 are compiled in.
- ALU_CARD_MUL_EN undefined:
  - op 11 behaves as reserved NOP: done pulses after 1 cycle, res and flags are unchanged.
  - busy is tied to 0.
  - No multiplier logic is synthesised.

## Test plan
- Reset: assert clear mid-cycle → res=0x00, all flags 0, busy=0, done=0; then LDR of each rsel 0-3 → 0x00.
- ADD a=0x7F b=0x01 → res=0x80, sign=1, z=0, c=0, v=1, done high exactly one cycle after the start edge.
- SUB a=0x05 b=0x05 → res=0x00, z=1, c=1, v=0; then ADC a=0xFF b=0x00 → res=0x00, c=1, z=1; then CLC → c=0, res stays 0x00.
- STR rsel=2 b=0xA5, then LDR rsel=2 on the next edge → res=0xA5, sign=1; LDR rsel=1 → 0x00.
- MUL a=0x12 b=0x11 (macro defined) → busy high for 8 cycles, done 9 cycles after start, res=0x32, c=1, v=0; a start with op=0 during busy is ignored.
- clear asserted 4 cycles into a MUL → busy=0 with no done pulse and res=0x00. With the macro undefined, op=11 → done the next cycle, busy=0, res and flags unchanged.
